mem_arbiter: RTL and testbench

- Shares one line-wide main-memory port between the instruction cache (read-only refill) and the data cache (refill and line write-back).
- Sits between the two caches and the memory model.
- Accepts level-held requests, grants one requester at a time and forwards its command to memory.
- Returns the line and a one-cycle ready pulse to the winner, then drains one cycle before re-arbitrating.

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arb_pick.sv | 32 +++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and sizes for the main-memory arbiter between the iCache and dCache.
// Optional round-robin priority is selected with the MEM_ARB_RR_EN macro.
package mem_arbiter_pkg;

    localparam int CACHE_LINE_SIZE = 128;
    localparam int DTAG_SIZE       = 22;
    localparam int INDEX_SIZE      = 6;
    localparam int LINE_ADDR_SIZE  = DTAG_SIZE + INDEX_SIZE;
    localparam int ARB_TIMEOUT     = 255;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_I = 2'd1,
        ARB_GNT_D = 2'd2,
        ARB_DRAIN = 2'd3
    } arb_state_t;

    // Watchdog stops at its ceiling so a very long stall cannot wrap it.
    function automatic logic [7:0] wd_step(input logic [7:0] wd);
        return (wd == 8'hFF) ? wd : wd + 8'd1;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection for the memory arbiter.
// MEM_ARB_RR_EN: simultaneous requests alternate based on the last served requester.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
`ifdef MEM_ARB_RR_EN
    input  logic last_d,
`endif
    output logic win_i,
    output logic win_d
);

    always_comb begin
        win_i = 1'b0;
        win_d = 1'b0;
`ifdef MEM_ARB_RR_EN
        if (i_req && d_req) begin
            win_i = last_d;
            win_d = ~last_d;
        end else begin
            win_i = i_req;
            win_d = d_req;
        end
`else
        win_d = d_req;
        win_i = i_req & ~d_req;
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one line-wide memory port between iCache refills and dCache refill/write-back.
// MEM_ARB_RR_EN selects round-robin instead of fixed dCache priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LINE_W  = CACHE_LINE_SIZE,
    parameter int ADDR_W  = LINE_ADDR_SIZE,
    parameter int TIMEOUT = ARB_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_line,
    output logic              i_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wline,
    output logic [LINE_W-1:0] d_line,
    output logic              d_ready,
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [LINE_W-1:0] m_wline,
    input  logic [LINE_W-1:0] m_rline,
    input  logic              m_ready,
    output logic              arb_err
);

    arb_state_t        state, state_n;
    logic              m_read_n, m_write_n, i_ready_n, d_ready_n, err_n;
    logic [ADDR_W-1:0] m_addr_n;
    logic [LINE_W-1:0] m_wline_n, i_line_n, d_line_n;
    logic [7:0]        wd, wd_n;
    logic              win_i, win_d;

`ifdef MEM_ARB_RR_EN
    logic last_d, last_d_n;
`endif

    mem_arb_pick u_pick (
        .i_req (i_mem_read),
        .d_req (d_mem_read | d_mem_write),
`ifdef MEM_ARB_RR_EN
        .last_d(last_d),
`endif
        .win_i (win_i),
        .win_d (win_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ARB_IDLE;
            m_read  <= 1'b0;
            m_write <= 1'b0;
            m_addr  <= '0;
            m_wline <= '0;
            i_line  <= '0;
            d_line  <= '0;
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            wd      <= '0;
            arb_err <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_d  <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            m_read  <= m_read_n;
            m_write <= m_write_n;
            m_addr  <= m_addr_n;
            m_wline <= m_wline_n;
            i_line  <= i_line_n;
            d_line  <= d_line_n;
            i_ready <= i_ready_n;
            d_ready <= d_ready_n;
            wd      <= wd_n;
            arb_err <= err_n;
`ifdef MEM_ARB_RR_EN
            last_d  <= last_d_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        m_read_n  = m_read;
        m_write_n = m_write;
        m_addr_n  = m_addr;
        m_wline_n = m_wline;
        i_line_n  = i_line;
        d_line_n  = d_line;
        i_ready_n = 1'b0;
        d_ready_n = 1'b0;
        wd_n      = wd;
        err_n     = arb_err;
`ifdef MEM_ARB_RR_EN
        last_d_n  = last_d;
`endif
        case (state)
            ARB_IDLE: begin
                wd_n = '0;
                if (win_d) begin
                    // A held write-back goes out before any refill of the same cache.
                    state_n   = ARB_GNT_D;
                    m_addr_n  = d_addr;
                    m_wline_n = d_wline;
                    m_write_n = d_mem_write;
                    m_read_n  = ~d_mem_write;
                end else if (win_i) begin
                    state_n   = ARB_GNT_I;
                    m_addr_n  = i_addr;
                    m_wline_n = '0;
                    m_write_n = 1'b0;
                    m_read_n  = 1'b1;
                end else begin
                    m_read_n  = 1'b0;
                    m_write_n = 1'b0;
                    m_addr_n  = '0;
                    m_wline_n = '0;
                end
            end
            ARB_GNT_I, ARB_GNT_D: begin
                if (m_ready) begin
                    if (state == ARB_GNT_I) begin
                        i_line_n  = m_rline;
                        i_ready_n = 1'b1;
                    end else begin
                        if (m_read)
                            d_line_n = m_rline;
                        d_ready_n = 1'b1;
                    end
                    m_read_n  = 1'b0;
                    m_write_n = 1'b0;
                    wd_n      = '0;
                    state_n   = ARB_DRAIN;
`ifdef MEM_ARB_RR_EN
                    last_d_n  = (state == ARB_GNT_D);
`endif
                end else begin
                    // Timeout only flags the stall; the grant keeps waiting for memory.
                    wd_n = wd_step(wd);
                    if (int'(wd) + 1 >= TIMEOUT)
                        err_n = 1'b1;
                end
            end
            ARB_DRAIN: state_n = ARB_IDLE;
            default:   state_n = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus hand-written corner sequences.
module tb_mem_arbiter;

    localparam int LW = 128;
    localparam int AW = 28;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_mem_read, d_mem_read, d_mem_write, m_ready;
    logic [AW-1:0] i_addr, d_addr;
    logic [LW-1:0] d_wline, m_rline;
    logic [LW-1:0] i_line, d_line, m_wline;
    logic          i_ready, d_ready, m_read, m_write, arb_err;
    logic [AW-1:0] m_addr;

    always #5 clk = ~clk;

    mem_arbiter #(.LINE_W(LW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_mem_read(i_mem_read), .i_addr(i_addr), .i_line(i_line), .i_ready(i_ready),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_addr(d_addr),
        .d_wline(d_wline), .d_line(d_line), .d_ready(d_ready),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wline(m_wline),
        .m_rline(m_rline), .m_ready(m_ready), .arb_err(arb_err)
    );

    typedef struct {
        logic          is_d;
        logic          is_wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wline;
        logic [LW-1:0] rline;
        int            lat;
    } vec_t;

    typedef struct {
        logic          is_d;
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wline;
        logic [LW-1:0] rline;
        logic [LW-1:0] line;
    } exp_t;

    exp_t          sb[$];
    vec_t          vecs[4];
    int            n_cmp = 0;
    int            n_fail = 0;
    logic [LW-1:0] mdl_i_line, mdl_d_line;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_a(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic is_d, input logic is_wr, input logic [AW-1:0] addr,
                                input logic [LW-1:0] wline, input logic [LW-1:0] rline, input int lat);
        vec_t v;
        v.is_d = is_d; v.is_wr = is_wr; v.addr = addr;
        v.wline = wline; v.rline = rline; v.lat = lat;
        return v;
    endfunction

    // Expected grant contents and the line the requester must end up holding.
    task automatic push_req(input logic is_d, input logic is_wr, input logic [AW-1:0] addr,
                            input logic [LW-1:0] wline, input logic [LW-1:0] rline);
        exp_t e;
        e.is_d  = is_d;
        e.rd    = ~is_wr;
        e.wr    = is_wr;
        e.addr  = addr;
        e.wline = is_d ? wline : '0;
        e.rline = rline;
        if (is_wr) begin
            e.line = mdl_d_line;
        end else if (is_d) begin
            e.line = rline;
            mdl_d_line = rline;
        end else begin
            e.line = rline;
            mdl_i_line = rline;
        end
        sb.push_back(e);
    endtask

    // Waits (bounded) for a grant, checks it against the scoreboard, replies after lat
    // cycles and checks the ready pulse. Returns at the negedge of the drain cycle.
    task automatic serve_one(input int lat, output int waited);
        exp_t e;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!(m_read || m_write) && waited < 20);
        if (sb.size() == 0) begin
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
            $fatal(1);
        end
        e = sb.pop_front();
        chk1("m_read", m_read, e.rd);
        chk1("m_write", m_write, e.wr);
        chk_a("m_addr", m_addr, e.addr);
        chk("m_wline", m_wline, e.wline);
        repeat (lat) @(negedge clk);
        chk1("m_cmd_held", e.rd ? m_read : m_write, 1'b1);
        m_rline = e.rline;
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        m_rline = '0;
        chk1("own_ready", e.is_d ? d_ready : i_ready, 1'b1);
        chk1("other_ready", e.is_d ? i_ready : d_ready, 1'b0);
        chk("line", e.is_d ? d_line : i_line, e.line);
        chk1("m_cmd_drop", m_read | m_write, 1'b0);
    endtask

    task automatic after_drain();
        @(negedge clk);
        chk1("ready_one_cycle", i_ready | d_ready, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mdl_i_line = '0;
        mdl_d_line = '0;
        sb.delete();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        int w;
        exp_t e;
        vecs[0] = mk(1'b0, 1'b0, 28'h0000010, '0, {16{8'hA5}}, 3);
        vecs[1] = mk(1'b1, 1'b0, 28'h0ABCDEF, {4{32'hCAFEF00D}}, {4{32'h01234567}}, 1);
        vecs[2] = mk(1'b1, 1'b1, 28'h00000FF, {8{16'h1234}}, {4{32'hDEADBEEF}}, 2);
        vecs[3] = mk(1'b0, 1'b0, 28'hFFFFFFF, '0, {LW{1'b1}}, 0);

        rst = 1'b1;
        i_mem_read = 1'b0; d_mem_read = 1'b0; d_mem_write = 1'b0; m_ready = 1'b0;
        i_addr = '0; d_addr = '0; d_wline = '0; m_rline = '0;
        mdl_i_line = '0; mdl_d_line = '0;
        repeat (2) @(negedge clk);
        chk1("rst_m_read", m_read, 1'b0);
        chk1("rst_m_write", m_write, 1'b0);
        chk_a("rst_m_addr", m_addr, '0);
        chk("rst_m_wline", m_wline, '0);
        chk1("rst_i_ready", i_ready, 1'b0);
        chk1("rst_d_ready", d_ready, 1'b0);
        chk("rst_i_line", i_line, '0);
        chk("rst_d_line", d_line, '0);
        chk1("rst_arb_err", arb_err, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Single-requester transactions.
        for (int k = 0; k < 4; k++) begin
            if (vecs[k].is_d) begin
                d_mem_read  = ~vecs[k].is_wr;
                d_mem_write = vecs[k].is_wr;
                d_addr      = vecs[k].addr;
                d_wline     = vecs[k].wline;
            end else begin
                i_mem_read = 1'b1;
                i_addr     = vecs[k].addr;
            end
            push_req(vecs[k].is_d, vecs[k].is_wr, vecs[k].addr, vecs[k].wline, vecs[k].rline);
            serve_one(vecs[k].lat, w);
            chk_i("grant_latency", w, 1);
            i_mem_read = 1'b0; d_mem_read = 1'b0; d_mem_write = 1'b0;
            after_drain();
            chk1("arb_err_quiet", arb_err, 1'b0);
        end

        // Simultaneous requests; dCache re-requests right after its first service.
        do_reset();
        i_mem_read = 1'b1; i_addr = 28'h0000111;
        d_mem_read = 1'b1; d_addr = 28'h0000222; d_wline = {4{32'h55AA55AA}};
        push_req(1'b1, 1'b0, 28'h0000222, {4{32'h55AA55AA}}, {4{32'h11112222}});
        serve_one(1, w);
        d_mem_read = 1'b0;
        after_drain();
        d_mem_read = 1'b1; d_addr = 28'h0000333;
`ifdef MEM_ARB_RR_EN
        push_req(1'b0, 1'b0, 28'h0000111, '0, {4{32'h33334444}});
        push_req(1'b1, 1'b0, 28'h0000333, {4{32'h55AA55AA}}, {4{32'h55556666}});
        serve_one(1, w);
        i_mem_read = 1'b0;
        after_drain();
        serve_one(1, w);
        d_mem_read = 1'b0;
        after_drain();
`else
        push_req(1'b1, 1'b0, 28'h0000333, {4{32'h55AA55AA}}, {4{32'h55556666}});
        push_req(1'b0, 1'b0, 28'h0000111, '0, {4{32'h33334444}});
        serve_one(1, w);
        d_mem_read = 1'b0;
        after_drain();
        serve_one(1, w);
        i_mem_read = 1'b0;
        after_drain();
`endif

        // Write-back and refill held together: write first, then the read.
        d_mem_write = 1'b1; d_mem_read = 1'b1;
        d_addr = 28'h0000444; d_wline = {4{32'h9ABCDEF0}};
        push_req(1'b1, 1'b1, 28'h0000444, {4{32'h9ABCDEF0}}, {4{32'hBADBAD00}});
        push_req(1'b1, 1'b0, 28'h0000444, {4{32'h9ABCDEF0}}, {4{32'h77778888}});
        serve_one(1, w);
        d_mem_write = 1'b0;
        after_drain();
        serve_one(1, w);
        d_mem_read = 1'b0;
        after_drain();

        // Watchdog: flag sets after TO grant cycles and stays set.
        i_mem_read = 1'b1; i_addr = 28'h0000555;
        push_req(1'b0, 1'b0, 28'h0000555, '0, {4{32'h0F0F0F0F}});
        e = sb.pop_front();
        @(negedge clk);
        chk1("to_grant", m_read, 1'b1);
        repeat (TO - 1) @(negedge clk);
        chk1("to_err_before", arb_err, 1'b0);
        @(negedge clk);
        chk1("to_err_set", arb_err, 1'b1);
        repeat (3) @(negedge clk);
        chk1("to_still_waiting", m_read, 1'b1);
        m_rline = e.rline; m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0; m_rline = '0;
        chk1("to_i_ready", i_ready, 1'b1);
        chk("to_i_line", i_line, e.line);
        i_mem_read = 1'b0;
        after_drain();
        chk1("to_err_sticky", arb_err, 1'b1);
        do_reset();
        chk1("to_err_cleared", arb_err, 1'b0);

        // Asynchronous reset in the middle of a dCache grant.
        d_mem_read = 1'b1; d_addr = 28'h0000666; d_wline = {4{32'h12121212}};
        @(negedge clk);
        chk1("ar_grant", m_read, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk1("ar_m_read", m_read, 1'b0);
        chk1("ar_m_write", m_write, 1'b0);
        chk1("ar_d_ready", d_ready, 1'b0);
        chk_a("ar_m_addr", m_addr, '0);
        @(negedge clk);
        rst = 1'b0;
        d_mem_read = 1'b0;
        m_rline = {4{32'hFEEDFACE}}; m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0; m_rline = '0;
        chk1("ar_late_ready", d_ready, 1'b0);
        chk("ar_d_line", d_line, '0);
        @(negedge clk);
        chk1("ar_idle_ready", d_ready | i_ready, 1'b0);
        chk1("ar_idle_cmd", m_read | m_write, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
